// File: rtl/fptd_enc_pkg.sv
// Shared types and the RSC trellis step for the terminated turbo encoder.
package fptd_enc_pkg;

  typedef enum logic [1:0] {
    DATA  = 2'd0,
    TERM1 = 2'd1,
    TERM2 = 2'd2
  } enc_state_t;

  // Bit 2 is s1 (most recent feedback), bit 0 is s3 (oldest).
  typedef logic [2:0] rsc_state_t;

  localparam int TAIL_LEN = 3;

  // Returns {next_state[2:0], parity}.
  function automatic logic [3:0] rsc_step(input rsc_state_t s, input logic u);
    logic f;
    f = u ^ s[1] ^ s[0];
    return {f, s[2], s[1], f ^ s[2] ^ s[0]};
  endfunction

endpackage

// File: rtl/rsc_encoder.sv
// One 8-state recursive systematic constituent encoder with a termination mode.
module rsc_encoder
  import fptd_enc_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_step,
  input  logic i_term,
  input  logic i_clear,
  input  logic i_u,
  output logic o_u_eff,
  output logic o_par
);

  rsc_state_t r_state;
  logic [3:0] w_step;

  // In termination mode the input cancels the feedback, driving the state to zero.
  assign o_u_eff = i_term ? (r_state[1] ^ r_state[0]) : i_u;
  assign w_step  = rsc_step(r_state, o_u_eff);
  assign o_par   = w_step[0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= '0;
    end else if (i_clear) begin
      r_state <= '0;
    end else if (i_step) begin
      r_state <= w_step[3:1];
    end
  end

  always @(posedge i_clk) begin
    if (!i_rst && i_clear) begin
      assert (i_step ? (w_step[3:1] == 3'b000) : (r_state == 3'b000));
    end
  end

endmodule

// File: rtl/turbo_encoder_term.sv
// LTE-style turbo encoder with 3+3 trellis-termination tail and a valid/ready output stream.
// Define FPTD_ENC_LLR_MAP_EN to add registered signed soft outputs (0 -> +LlrMag, 1 -> -LlrMag).
module turbo_encoder_term
  import fptd_enc_pkg::*;
#(
  parameter int KMax   = 6144,
  parameter int N      = 6,
  parameter int LlrMag = 31
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_x,
  input  logic       in_xi,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sys,
  output logic       out_par1,
  output logic       out_par2,
  output logic [1:0] out_tail,
  output logic [1:0] o_dbg_state,
  output logic       FrameErr
`ifdef FPTD_ENC_LLR_MAP_EN
  ,
  output logic signed [N-1:0] out_sys_llr,
  output logic signed [N-1:0] out_par1_llr,
  output logic signed [N-1:0] out_par2_llr
`endif
);

  localparam int CW = $clog2(KMax + 1);

  if (LlrMag < 1 || LlrMag >= (1 << (N - 1))) begin : g_llr_range
    $error("LlrMag must fit in N-1 bits");
  end

  // Handshake: a triple transfers on a rising edge where out_valid && out_ready;
  // a pair transfers where in_valid && in_ready. The output register may be
  // reloaded only when it is empty or being drained in the same cycle.

  enc_state_t    r_state;
  logic [CW-1:0] r_bit_cnt;
  logic [1:0]    r_tail_cnt;
  logic          r_out_valid;
  logic          r_sys, r_par1, r_par2, r_frame_err;
  logic [1:0]    r_tail;

  logic          w_slot_free, w_adv, w_take, w_at_kmax, w_tail_last, w_done;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_u1, w_u2, w_par1, w_par2;
  logic          w_load, w_ld_sys, w_ld_p1, w_ld_p2;
  logic [1:0]    w_ld_tail;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_adv       = Enable && w_slot_free;
  assign in_ready    = Enable && !Reset && (r_state == DATA) && w_slot_free;
  assign w_take      = in_valid && in_ready;
  assign w_cnt_nxt   = r_bit_cnt + CW'(1);
  assign w_at_kmax   = (w_cnt_nxt == CW'(KMax));
  assign w_tail_last = (r_tail_cnt == 2'(TAIL_LEN - 1));
  assign w_done      = (r_state == TERM2) && w_adv && w_tail_last;

  rsc_encoder u_rsc1 (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_step  ((r_state == DATA) ? w_take : ((r_state == TERM1) && w_adv)),
    .i_term  (r_state == TERM1),
    .i_clear (w_done),
    .i_u     (in_x),
    .o_u_eff (w_u1),
    .o_par   (w_par1)
  );

  rsc_encoder u_rsc2 (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_step  ((r_state == DATA) ? w_take : ((r_state == TERM2) && w_adv)),
    .i_term  (r_state == TERM2),
    .i_clear (w_done),
    .i_u     (in_xi),
    .o_u_eff (w_u2),
    .o_par   (w_par2)
  );

  always_comb begin
    w_load    = w_take;
    w_ld_sys  = in_x;
    w_ld_p1   = w_par1;
    w_ld_p2   = w_par2;
    w_ld_tail = 2'd0;
    case (r_state)
      TERM1: begin
        w_load    = w_adv;
        w_ld_sys  = w_u1;
        w_ld_p2   = 1'b0;
        w_ld_tail = 2'd1;
      end
      TERM2: begin
        w_load    = w_adv;
        w_ld_sys  = w_u2;
        w_ld_p1   = 1'b0;
        w_ld_tail = 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= DATA;
      r_bit_cnt   <= '0;
      r_tail_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_sys       <= 1'b0;
      r_par1      <= 1'b0;
      r_par2      <= 1'b0;
      r_tail      <= 2'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_sys       <= w_ld_sys;
        r_par1      <= w_ld_p1;
        r_par2      <= w_ld_p2;
        r_tail      <= w_ld_tail;
        case (r_state)
          DATA: begin
            r_bit_cnt   <= w_cnt_nxt;
            r_frame_err <= w_at_kmax && !in_last;
            if (in_last || w_at_kmax) begin
              r_state    <= TERM1;
              r_tail_cnt <= '0;
            end
          end
          TERM1: begin
            r_tail_cnt <= w_tail_last ? 2'd0 : r_tail_cnt + 2'd1;
            if (w_tail_last) r_state <= TERM2;
          end
          TERM2: begin
            r_tail_cnt <= w_tail_last ? 2'd0 : r_tail_cnt + 2'd1;
            if (w_tail_last) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end
          end
          default: r_state <= DATA;
        endcase
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_sys     = r_sys;
  assign out_par1    = r_par1;
  assign out_par2    = r_par2;
  assign out_tail    = r_tail;
  assign FrameErr    = r_frame_err;
  assign o_dbg_state = r_state;

`ifdef FPTD_ENC_LLR_MAP_EN
  localparam logic signed [N-1:0] LLR_POS = N'(LlrMag);

  function automatic logic signed [N-1:0] llr_of(input logic b);
    return b ? -LLR_POS : LLR_POS;
  endfunction

  // Absent tail parity slots carry no information, hence 0.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_sys_llr  <= '0;
      out_par1_llr <= '0;
      out_par2_llr <= '0;
    end else if (w_load) begin
      out_sys_llr  <= llr_of(w_ld_sys);
      out_par1_llr <= (r_state == TERM2) ? '0 : llr_of(w_ld_p1);
      out_par2_llr <= (r_state == TERM1) ? '0 : llr_of(w_ld_p2);
    end
  end
`endif

endmodule

// File: tb/tb_turbo_encoder_term.sv
// Directed/randomized bench for turbo_encoder_term with a recurrence-based reference model.
module tb_turbo_encoder_term;

  localparam int K_MAX = 48;

  logic       Clock = 1'b0;
  logic       Reset, Enable, in_valid, in_x, in_xi, in_last, out_ready;
  logic       in_ready, out_valid, out_sys, out_par1, out_par2, FrameErr;
  logic [1:0] out_tail, dbg_state;
`ifdef FPTD_ENC_LLR_MAP_EN
  logic [5:0] sys_llr, p1_llr, p2_llr;
`endif

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int fe_cnt = 0;
  int fe_idx = -1;
  logic force_stall = 1'b0;
  logic ready_rand = 1'b0;
  logic [4:0] exp_q[$];
  bit fx[0:63];
  bit fxi[0:63];

  turbo_encoder_term #(.KMax(K_MAX)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Enable      (Enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_xi       (in_xi),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sys     (out_sys),
    .out_par1    (out_par1),
    .out_par2    (out_par2),
    .out_tail    (out_tail),
    .o_dbg_state (dbg_state),
    .FrameErr    (FrameErr)
`ifdef FPTD_ENC_LLR_MAP_EN
    ,
    .out_sys_llr  (sys_llr),
    .out_par1_llr (p1_llr),
    .out_par2_llr (p2_llr)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: w_k = u ^ w_{k-2} ^ w_{k-3}, parity = w_k ^ w_{k-1} ^ w_{k-3};
  // tail input chosen so that w_k = 0.
  task automatic model_frame(input int off, input int len);
    bit h1[$];
    bit h2[$];
    bit w, u, p1, p2;
    int n;
    h1 = '{0, 0, 0};
    h2 = '{0, 0, 0};
    for (int k = 0; k < len; k++) begin
      n = h1.size();
      w = fx[off+k] ^ h1[n-2] ^ h1[n-3];
      p1 = w ^ h1[n-1] ^ h1[n-3];
      h1.push_back(w);
      w = fxi[off+k] ^ h2[n-2] ^ h2[n-3];
      p2 = w ^ h2[n-1] ^ h2[n-3];
      h2.push_back(w);
      exp_q.push_back({fx[off+k], p1, p2, 2'd0});
    end
    for (int t = 0; t < 3; t++) begin
      n = h1.size();
      u = h1[n-2] ^ h1[n-3];
      w = u ^ h1[n-2] ^ h1[n-3];
      p1 = w ^ h1[n-1] ^ h1[n-3];
      h1.push_back(w);
      exp_q.push_back({u, p1, 1'b0, 2'd1});
    end
    for (int t = 0; t < 3; t++) begin
      n = h2.size();
      u = h2[n-2] ^ h2[n-3];
      w = u ^ h2[n-2] ^ h2[n-3];
      p2 = w ^ h2[n-1] ^ h2[n-3];
      h2.push_back(w);
      exp_q.push_back({u, 1'b0, p2, 2'd2});
    end
  endtask

  task automatic push_scenario1();
    exp_q.push_back(5'b11100);
    exp_q.push_back(5'b01001);
    exp_q.push_back(5'b10001);
    exp_q.push_back(5'b11001);
    exp_q.push_back(5'b00110);
    exp_q.push_back(5'b10010);
    exp_q.push_back(5'b10110);
  endtask

  task automatic rand_bits(input int n);
    for (int k = 0; k < n; k++) begin
      fx[k]  = 1'($urandom_range(0, 1));
      fxi[k] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_bit(input logic x, input logic xi, input logic last);
    int t;
    @(negedge Clock);
    in_valid = 1'b1;
    in_x = x;
    in_xi = xi;
    in_last = last;
    #1;
    t = 0;
    while (!in_ready && t < 1000) begin
      @(negedge Clock);
      #1;
      t++;
    end
    chk("in_ready_timeout", 16'(t < 1000), 16'd1);
    @(posedge Clock);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_frame(input int len, input int last_idx);
    for (int k = 0; k < len; k++) send_bit(fx[k], fxi[k], k == last_idx);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge Clock);
      t++;
    end
    chk(tag, 16'(exp_q.size()), 16'd0);
    repeat (3) @(negedge Clock);
    #2;
    chk("idle_after_frame", out_valid, 1'b0);
  endtask

  task automatic stall5();
    force_stall = 1'b1;
    repeat (5) begin
      @(negedge Clock);
      #2;
      chk("stall_valid", out_valid, 1'b1);
    end
    force_stall = 1'b0;
  endtask

  task automatic freeze4();
    @(negedge Clock);
    Enable = 1'b0;
    #1;
    chk("frz_in_ready", in_ready, 1'b0);
    repeat (3) @(negedge Clock);
    #2;
    chk("frz_valid", out_valid, 1'b0);
    @(negedge Clock);
    Enable = 1'b1;
  endtask

  task automatic ready_loop();
    forever begin
      @(posedge Clock);
      #2;
      out_ready = force_stall ? 1'b0 : (ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  endtask

  task automatic monitor_loop();
    logic held;
    logic [4:0] held_v, obs, e;
    held = 1'b0;
    forever begin
      @(negedge Clock);
      #1;
      obs = {out_sys, out_par1, out_par2, out_tail};
      if (Reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_fields", obs, held_v);
        end
        if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 1'b0);
        held = out_valid && !out_ready;
        held_v = obs;
        if (FrameErr) begin
          fe_cnt++;
          fe_idx = pop_cnt;
        end
        if (out_valid && out_ready) begin
          chk("extra_triple", 16'(exp_q.size() != 0), 16'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("triple", obs, e);
`ifdef FPTD_ENC_LLR_MAP_EN
            chk("sys_llr", sys_llr, e[4] ? 6'h21 : 6'd31);
            chk("par1_llr", p1_llr, (e[1:0] == 2'd2) ? 6'd0 : (e[3] ? 6'h21 : 6'd31));
            chk("par2_llr", p2_llr, (e[1:0] == 2'd1) ? 6'd0 : (e[2] ? 6'h21 : 6'd31));
`endif
          end
          pop_cnt++;
        end
      end
    end
  endtask

  initial begin
    int base, fe0, len;
    Reset = 1'b1;
    Enable = 1'b0;
    in_valid = 1'b0;
    in_x = 1'b0;
    in_xi = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    fork
      monitor_loop();
      ready_loop();
    join_none

    repeat (2) @(negedge Clock);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_fields", {out_sys, out_par1, out_par2, out_tail}, 5'd0);
    chk("rst_frame_err", FrameErr, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    @(negedge Clock);
    Reset = 1'b0;
    Enable = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1'b1);

    // One-bit frame with the published triple list.
    push_scenario1();
    send_bit(1'b1, 1'b1, 1'b1);
    wait_drain("s1_drain");

    // 40-bit all-zero frame.
    for (int k = 0; k < 40; k++) begin
      fx[k] = 1'b0;
      fxi[k] = 1'b0;
    end
    fe0 = fe_cnt;
    model_frame(0, 40);
    send_frame(40, 39);
    wait_drain("zero_drain");
    chk("zero_no_frame_err", 16'(fe_cnt), 16'(fe0));

    // Backpressure mid-data and mid-TERM1.
    rand_bits(24);
    model_frame(0, 24);
    for (int k = 0; k < 24; k++) begin
      send_bit(fx[k], fxi[k], k == 23);
      if (k == 10) stall5();
    end
    @(posedge Clock);
    #1;
    stall5();
    wait_drain("stall_drain");

    // Random frames under random downstream readiness.
    ready_rand = 1'b1;
    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(1, 30);
      rand_bits(len);
      model_frame(0, len);
      send_frame(len, len - 1);
      wait_drain("rand_drain");
    end
    ready_rand = 1'b0;

    // Enable freeze in data and in tail.
    rand_bits(12);
    model_frame(0, 12);
    for (int k = 0; k < 12; k++) begin
      send_bit(fx[k], fxi[k], k == 11);
      if (k == 5) freeze4();
    end
    @(posedge Clock);
    #1;
    freeze4();
    wait_drain("freeze_drain");

    // in_last exactly on the K_MAX-th bit: normal termination.
    rand_bits(K_MAX);
    fe0 = fe_cnt;
    model_frame(0, K_MAX);
    send_frame(K_MAX, K_MAX - 1);
    wait_drain("kmax_last_drain");
    chk("kmax_last_no_err", 16'(fe_cnt), 16'(fe0));

    // Overflow: K_MAX+4 bits, in_last only on the final one.
    rand_bits(K_MAX + 4);
    fe0 = fe_cnt;
    base = pop_cnt;
    model_frame(0, K_MAX);
    model_frame(K_MAX, 4);
    send_frame(K_MAX + 4, K_MAX + 3);
    wait_drain("ovf_drain");
    chk("ovf_err_count", 16'(fe_cnt), 16'(fe0 + 1));
    chk("ovf_err_index", 16'(fe_idx), 16'(base + K_MAX - 1));

    // Reset during the second TERM1 output, then the one-bit frame again.
    push_scenario1();
    send_bit(1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge Clock);
    #3;
    Reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_fields", {out_sys, out_par1, out_par2, out_tail}, 5'd0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_state", dbg_state, 2'd0);
    exp_q.delete();
    @(negedge Clock);
    Reset = 1'b0;
    push_scenario1();
    send_bit(1'b1, 1'b1, 1'b1);
    wait_drain("s1_after_rst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/turbo_encoder_term.md
Name: turbo_encoder_term

Overview:
- LTE-style parallel-concatenated turbo encoder; the transmit-side counterpart of the fully parallel turbo decoder sections.
- Each cycle it takes one natural-order bit x and one interleaved bit xi; the interleaver is external.
- It drives two 8-state RSC constituent encoders and emits systematic, parity-1 and parity-2 bits through a valid/ready stream.
- After the last bit it appends 3+3 trellis-termination cycles, so the decoder sees zero start and end states.

Parameters:
- KMax, 6144, maximum frame length in bits; exceeding it forces termination.
- N, 6, soft-output width, used only with the optional feature.
- LlrMag, 31, soft-output magnitude, used only with the optional feature; must fit in N-1 bits.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Enable  in  1  global advance enable; when low the block is fully frozen.
- in_valid  in  1  input bit pair valid.
- in_ready  out  1  block accepts a pair this cycle.
- in_x  in  1  natural-order information bit.
- in_xi  in  1  interleaved information bit.
- in_last  in  1  marks the final pair of the frame.
- out_valid  out  1  output triple valid.
- out_ready  in  1  downstream accepts the triple.
- out_sys  out  1  systematic bit (x, or tail x during termination).
- out_par1  out  1  encoder-1 parity.
- out_par2  out  1  encoder-2 parity.
- out_tail  out  2  output phase: 0=data, 1=tail of encoder 1, 2=tail of encoder 2.
- FrameErr  out  1  one-cycle pulse when KMax is hit without in_last.

Behaviour:
- Reset: all outputs 0, FSM=DATA, both RSC states 000, bit counter 0, tail counter 0.
- RSC definition:
  - State (s1,s2,s3).
  - Feedback f = u^s2^s3.
  - Parity z = f^s1^s3.
  - Next state (f,s1,s2).
- FSM has three states: DATA, TERM1, TERM2.
- Output register and handshake:
  - Single output register; update is allowed when "slot free" = !out_valid || out_ready.
  - in_ready = Enable && FSM==DATA && slot free.
- DATA:
  - A pair transfers on in_valid && in_ready.
  - Register out_sys=x, out_par1=z1, out_par2=z2, out_tail=0, out_valid=1.
  - Step both RSCs and increment the bit counter.
  - Transition to TERM1 when in_last is accepted, or when the accepted bit brings the counter to KMax.
  - In the KMax case, also pulse FrameErr in the same cycle as the register update.
- TERM1 (3 outputs):
  - Each time the slot is free and Enable=1, drive u=s2^s3 into RSC1 (f=0).
  - Output sys=u, par1=z1, par2=0, out_tail=1.
  - After the 3rd output, move to TERM2.
- TERM2 (3 outputs): same rule applied to RSC2; output sys=u', par1=0, par2=z2, out_tail=2.
- After the 3rd TERM2 output:
  - Return to DATA; bit counter cleared.
  - RSC states are 000 by construction; the RTL asserts this.
- Latency: 1 cycle from input acceptance to out_valid. Frame of K bits produces exactly K+6 output triples.
- Backpressure: while out_valid && !out_ready, output fields are held stable and no state advances.
- No pending-triple loss: out_valid drops only when out_ready=1 and no new triple is loaded.
- Enable=0 freezes everything, except that the output register still completes a handshake (out_valid clears) if out_ready=1.
- Reset mid-frame or mid-tail: immediate return to the reset state; the partial frame is discarded.
- in_last on the KMax-th bit is treated as a normal last with no FrameErr.

Optional Feature:
- Macro FPTD_ENC_LLR_MAP_EN adds three outputs: out_sys_llr, out_par1_llr, out_par2_llr, each signed N-bit, out.
- Mapping: bit 0 -> +LlrMag, bit 1 -> -LlrMag.
- A parity slot that is absent during a tail phase (par2 in TERM1, par1 in TERM2) -> 0.
- The soft outputs are registered alongside the bits, with the same valid.
- Without the macro, these ports and their logic do not exist.

Decomposition:
- Package fptd_enc_pkg holds:
  - typedef enum {DATA,TERM1,TERM2} enc_state_t;
  - typedef logic [2:0] rsc_state_t;
  - TAIL_LEN=3;
  - a function rsc_step(rsc_state_t, u) returning {next state, parity}.
- Sub-module rsc_encoder is instantiated twice. It holds the state register and has step-enable, termination-mode and clear inputs, producing u_eff and parity.

Test Plan:
- 1-bit frame, x=1, xi=1, in_last=1, out_ready=1 -> 7 triples (sys,par1,par2,tail):
  - (1,1,1,0)
  - (0,1,0,1) (1,0,0,1) (1,1,0,1)
  - (0,0,1,2) (1,0,0,2) (1,0,1,2)
- 40-bit all-zero frame -> 46 triples with all bits 0; out_tail sequence 40×0, 3×1, 3×2; FrameErr never pulses.
- Backpressure: out_ready low for 5 cycles mid-data and again mid-TERM1 -> outputs stable, in_ready=0, bit sequence identical to the no-stall run.
- KMax=16, 20 bits streamed with no in_last -> FrameErr pulses on the 16th bit; 6 tail triples follow; bits 17-20 encode as a new frame from zero state.
- Reset asserted during the 2nd TERM1 output -> all outputs 0 asynchronously; a following 1-bit frame reproduces scenario 1 exactly.
- With FPTD_ENC_LLR_MAP_EN, N=6, LlrMag=31, scenario 1:
  - 1st triple LLRs = -31,-31,-31;
  - 1st TERM1 triple = +31,-31,0.
